// File: rtl/tbcm_stream_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tbcm_stream_arbiter_pkg
// Description : Shared types and helpers for the packet-locked round-robin
//               stream arbiter: FSM state type, round-robin grant picker and
//               post-packet priority-mask update.
// Revision    : 1.0 - initial release
// ============================================================================
package tbcm_stream_arbiter_pkg;

    // Largest supported requester count; helpers work on this width and
    // callers truncate to their own ENTRIES.
    localparam int unsigned c_MAX_ENTRIES = 32;
    localparam int unsigned c_STATE_W     = 1;
    localparam logic [c_MAX_ENTRIES-1:0] c_ONE = 32'd1;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Lowest-index request inside the priority mask; if the mask hides every
    // request, wrap around to the lowest-index request overall. One-hot or 0.
    function automatic logic [c_MAX_ENTRIES-1:0] next_grant(
        input logic [c_MAX_ENTRIES-1:0] request,
        input logic [c_MAX_ENTRIES-1:0] mask
    );
        logic [c_MAX_ENTRIES-1:0] w_masked;
        logic [c_MAX_ENTRIES-1:0] w_pick;
        w_masked = request & mask;
        w_pick   = (|w_masked) ? w_masked : request;
        // Two's-complement trick isolates the lowest set bit.
        return w_pick & (~w_pick + c_ONE);
    endfunction

    // Priority mask after a packet from 'grant' finishes: every index strictly
    // above the winner. When the winner is the top entry (or grant is empty)
    // the mask reopens to all ones so entry 0 leads again.
    function automatic logic [c_MAX_ENTRIES-1:0] next_mask(
        input logic [c_MAX_ENTRIES-1:0] grant,
        input int unsigned              entries
    );
        logic [c_MAX_ENTRIES-1:0] w_lim;
        logic [c_MAX_ENTRIES-1:0] w_above;
        // A shift by 32 yields 0, so 32 entries gives an all-ones limit.
        w_lim   = (c_ONE << entries) - c_ONE;
        w_above = ~(grant | (grant - c_ONE)) & w_lim;
        return (|w_above) ? w_above : w_lim;
    endfunction

endpackage : tbcm_stream_arbiter_pkg
`default_nettype wire

// File: rtl/tbcm_stream_arbiter_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tbcm_mux
// Description : Generic N:1 selector. With ONE_HOT=1 the select is a one-hot
//               (or all-zero) vector and the output is an AND-OR of the
//               inputs, giving zero when nothing is selected. With ONE_HOT=0
//               the low bits of the select form a binary index.
// Ports       : i_sel  [ENTRIES]           select vector
//               i_data DATA_TYPE [ENTRIES] candidate payloads
//               o_data DATA_TYPE           selected payload
// Revision    : 1.0 - initial release
// ============================================================================
module tbcm_mux
    import tbcm_stream_arbiter_pkg::*;
#(
    parameter bit          ONE_HOT   = 1'b1,
    parameter int unsigned ENTRIES   = 4,
    parameter type         DATA_TYPE = logic
) (
    input  logic [ENTRIES-1:0] i_sel,
    input  DATA_TYPE           i_data [ENTRIES],
    output DATA_TYPE           o_data
);

    generate
        if (ONE_HOT) begin : g_one_hot
            logic [$bits(DATA_TYPE)-1:0] w_acc;
            always_comb begin
                w_acc = '0;
                for (int i = 0; i < int'(ENTRIES); i++) begin
                    if (i_sel[i]) begin
                        w_acc = w_acc | i_data[i];
                    end
                end
            end
            assign o_data = DATA_TYPE'(w_acc);
        end else begin : g_binary
            localparam int unsigned c_IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
            assign o_data = i_data[i_sel[c_IDX_W-1:0]];
        end
    endgenerate

endmodule : tbcm_mux
`default_nettype wire

// File: rtl/tbcm_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tbcm_stream_arbiter
// Description : Round-robin, packet-locked arbiter sharing one valid/ready
//               stream channel between ENTRIES requesters. The registered
//               one-hot grant drives one-hot muxes for payload and last flag
//               and is held until the granted packet's last beat transfers.
// Ports       : i_clk, i_rst_n (synchronous, active-low)
//               i_valid/o_ready/i_data/i_last  per-requester stream side
//               o_valid/i_ready/o_data/o_last  shared downstream side
//               o_grant                        registered one-hot grant
// Options     : TBCM_STREAM_ARBITER_BACK_TO_BACK_EN - re-arbitrate on the
//               last-beat transfer so packets from different requesters
//               follow with no idle bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module tbcm_stream_arbiter
    import tbcm_stream_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter type         DATA_TYPE = logic [WIDTH-1:0],
    parameter int unsigned ENTRIES   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [ENTRIES-1:0] i_valid,
    output logic [ENTRIES-1:0] o_ready,
    input  DATA_TYPE           i_data [ENTRIES],
    input  logic [ENTRIES-1:0] i_last,
    output logic               o_valid,
    input  logic               i_ready,
    output DATA_TYPE           o_data,
    output logic               o_last,
    output logic [ENTRIES-1:0] o_grant
);

    state_e             r_state;
    logic [ENTRIES-1:0] r_grant;
    logic [ENTRIES-1:0] r_mask;

    logic [ENTRIES-1:0] w_idle_grant;
    logic [ENTRIES-1:0] w_done_mask;
    logic               w_xfer_last;
    logic               w_last_sel;
    logic               w_last_arr [ENTRIES];

    // ------------------------------------------------------------------
    // Datapath: the grant is empty outside BUSY, so valid/ready/data/last
    // all fall to zero while idle without further gating.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_last_unpack
            assign w_last_arr[g] = i_last[g];
        end
    endgenerate

    tbcm_mux #(
        .ONE_HOT   (1'b1),
        .ENTRIES   (ENTRIES),
        .DATA_TYPE (DATA_TYPE)
    ) u_data_mux (
        .i_sel  (r_grant),
        .i_data (i_data),
        .o_data (o_data)
    );

    tbcm_mux #(
        .ONE_HOT   (1'b1),
        .ENTRIES   (ENTRIES),
        .DATA_TYPE (logic)
    ) u_last_mux (
        .i_sel  (r_grant),
        .i_data (w_last_arr),
        .o_data (w_last_sel)
    );

    assign o_valid     = |(i_valid & r_grant);
    assign o_last      = w_last_sel;
    assign o_ready     = r_grant & {ENTRIES{i_ready}};
    assign o_grant     = r_grant;
    assign w_xfer_last = o_valid & i_ready & o_last;

    // ------------------------------------------------------------------
    // Arbitration candidates
    // ------------------------------------------------------------------
    assign w_idle_grant = ENTRIES'(next_grant(32'(i_valid), 32'(r_mask)));
    assign w_done_mask  = ENTRIES'(next_mask(32'(r_grant), ENTRIES));

`ifdef TBCM_STREAM_ARBITER_BACK_TO_BACK_EN
    // Next winner chosen alongside the finishing packet: updated pointer,
    // finishing requester excluded so it cannot immediately re-win.
    logic [ENTRIES-1:0] w_b2b_grant;
    assign w_b2b_grant = ENTRIES'(next_grant(32'(i_valid & ~r_grant), 32'(w_done_mask)));
`endif

    // ------------------------------------------------------------------
    // FSM and priority pointer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_mask  <= '1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|i_valid) begin
                        r_grant <= w_idle_grant;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // Grant is locked until the last beat actually transfers.
                    if (w_xfer_last) begin
                        r_mask <= w_done_mask;
`ifdef TBCM_STREAM_ARBITER_BACK_TO_BACK_EN
                        if (|w_b2b_grant) begin
                            r_grant <= w_b2b_grant;
                        end else begin
                            r_grant <= '0;
                            r_state <= IDLE;
                        end
`else
                        r_grant <= '0;
                        r_state <= IDLE;
`endif
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : tbcm_stream_arbiter
`default_nettype wire

// File: tb/tb_tbcm_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tbcm_stream_arbiter
// Description : Self-checking bench for tbcm_stream_arbiter (ENTRIES=4,
//               WIDTH=8). A behavioural model (busy flag, granted index,
//               round-robin start index) predicts every output each cycle;
//               directed scenarios add explicit grant-order checks, followed
//               by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tbcm_stream_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] valid;
    logic [N-1:0] ready_o;
    logic [W-1:0] data [N];
    logic [N-1:0] last;
    logic         ovalid;
    logic         iready;
    logic [W-1:0] odata;
    logic         olast;
    logic [N-1:0] grant;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_busy;
    int m_idx;
    int m_ptr;

    logic [N-1:0] served [$];

    always #5 clk = ~clk;

    tbcm_stream_arbiter #(
        .WIDTH   (W),
        .ENTRIES (N)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid),
        .o_ready (ready_o),
        .i_data  (data),
        .i_last  (last),
        .o_valid (ovalid),
        .i_ready (iready),
        .o_data  (odata),
        .o_last  (olast),
        .o_grant (grant)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Circular scan from 'start': first requester at or above start, else
    // wrap to the lowest. -1 when nobody requests.
    function automatic int pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) data[k] = W'($urandom);
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic tick();
        logic [N-1:0] eg;
        logic         ev;
        logic         el;
        logic [W-1:0] ed;
        int           nx;
        #1;
        eg = '0;
        if (m_busy) eg[m_idx] = 1'b1;
        ev = m_busy && valid[m_idx];
        el = m_busy && last[m_idx];
        ed = m_busy ? data[m_idx] : '0;
        chk("grant", 32'(grant), 32'(eg));
        chk("valid", 32'(ovalid), 32'(ev));
        chk("ready", 32'(ready_o), 32'(iready ? eg : '0));
        chk("data", 32'(odata), 32'(ed));
        chk("last", 32'(olast), 32'(el));
        if (ovalid && iready && olast) served.push_back(grant);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            nx = pick(valid, m_ptr);
            if (nx >= 0) begin
                m_busy = 1'b1;
                m_idx  = nx;
            end
        end else if (ev && iready && el) begin
            m_ptr = (m_idx + 1) % N;
`ifdef TBCM_STREAM_ARBITER_BACK_TO_BACK_EN
            nx = pick(valid & ~eg, m_ptr);
            if (nx >= 0) m_idx = nx;
            else m_busy = 1'b0;
`else
            m_busy = 1'b0;
`endif
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [N-1:0] served_at(input int i);
        if (i < served.size()) return served[i];
        return 'x;
    endfunction

    initial begin
        logic [N-1:0] exp_rot [5];
        logic         rdy_pat [4];
        exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1};

        // ---- power-up: settle reset before the model takes over ----
        rst_n  = 1'b0;
        valid  = 4'b1111;
        last   = 4'b1111;
        iready = 1'b1;
        rand_data();
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_busy = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;

        // ---- reset held 3 cycles with every requester valid ----
        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(ovalid), 32'h0);
        chk("rst_ready", 32'(ready_o), 32'h0);
        rst_n = 1'b1;
        served.delete();
        tick();
        chk("rel_grant", 32'(grant), 32'h1);

        // ---- rotation: all four send single-beat packets ----
        for (int c = 0; c < 10; c++) begin
            rand_data();
            tick();
        end
        for (int i = 0; i < 5; i++)
            chk($sformatf("rot%0d", i), 32'(served_at(i)), 32'(exp_rot[i]));

        // ---- packet lock: requester 2, 3 beats, ready 1,0,1,1 ----
        do_reset();
        valid = 4'b0010;
        last  = 4'b0010;
        tick();
        tick();                 // serve requester 1 -> pointer at 2
        valid = 4'b0101;
        last  = 4'b0001;
        tick();
        for (int c = 0; c < 4; c++) begin
            iready  = rdy_pat[c];
            last[2] = (c == 3);
            rand_data();
            #1;
            chk($sformatf("lock_grant%0d", c), 32'(grant), 32'h4);
            tick();
        end
        iready = 1'b1;
        valid  = 4'b0001;
        for (int k = 0; k < 3 && grant == '0; k++) tick();
        chk("lock_next", 32'(grant), 32'h1);
        tick();

        // ---- wrap with sparse requests ----
        do_reset();
        valid = 4'b1000;
        last  = 4'b1111;
        tick();
        tick();                 // requester 3 served
        valid = 4'b1010;
        served.delete();
        repeat (4) tick();
        chk("wrap0", 32'(served_at(0)), 32'h2);
        chk("wrap1", 32'(served_at(1)), 32'h8);

        // ---- valid gap on granted requester 1 ----
        do_reset();
        valid = 4'b0010;
        last  = 4'b0000;
        tick();
        tick();
        valid = 4'b1101;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("gap_valid", 32'(ovalid), 32'h0);
            chk("gap_grant", 32'(grant), 32'h2);
            chk("gap_ready", 32'(ready_o), 32'h2);
            tick();
        end
        valid = 4'b0010;
        last  = 4'b0010;
        tick();

        // ---- reset in the middle of a 4-beat packet ----
        do_reset();
        valid = 4'b0100;
        last  = 4'b0100;
        tick();
        tick();                 // requester 2 served -> pointer at 3
        valid = 4'b1000;
        last  = 4'b0000;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_valid", 32'(ovalid), 32'h0);
        rst_n = 1'b1;
        valid = 4'b1111;
        last  = 4'b1111;
        tick();
        chk("midrst_ptr", 32'(grant), 32'h1);

        // ---- randomized phase ----
        do_reset();
        for (int c = 0; c < 600; c++) begin
            valid  = N'($urandom);
            last   = N'($urandom) & N'($urandom);
            iready = ($urandom_range(0, 3) != 0);
            rst_n  = ($urandom_range(0, 63) != 0);
            rand_data();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tbcm_stream_arbiter
`default_nettype wire
